write_scoreboard: RTL and testbench
===================================

WRITE_SCOREBOARD -- requirements
Module: write_scoreboard

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-low; sampled on rising clock edge.
REQ-003 SHALL have ports: issue_valid  in  1  decode-stage instruction presented for issue.
REQ-004 SHALL have ports: issue_opcode  in  5  instruction opcode field.
REQ-005 SHALL have ports: issue_aluop  in  5  ALU op field, meaningful only when issue_opcode=00000.
REQ-006 SHALL have ports: issue_rd  in  5  destination field of the instruction.
REQ-007 SHALL have ports: chk_a_en / chk_b_en  in  1 each  source-operand check enables from the decode read-decoders.
REQ-008 SHALL have ports: chk_a / chk_b  in  5 each  source register numbers.
REQ-009 SHALL have ports: wb_valid  in  1  writeback-stage register write occurring this cycle.
REQ-010 SHALL have ports: wb_reg  in  5  register written at writeback.
REQ-011 SHALL have ports: md_done  in  1  multdiv unit result ready, one-cycle pulse.
REQ-012 SHALL have ports: stall  out  1  combinational; decode must hold instruction.
REQ-013 SHALL have ports: md_busy  out  1  registered; mult/div in flight.
REQ-014 SHALL have ports: pending  out  32  registered; bit i = count[i] nonzero.
REQ-015 SHALL have ports: err  out  1  registered, sticky; retire underflow seen.

Function
REQ-016 Write decode SHALL produce writes=1, target=issue_rd for opcode 00000 (any aluop), 00101 addi, 01000 lw; target=31 for 00011 jal; target=30 for 10101 setx; writes=0 for all others.
REQ-017 Target register 0 SHALL be treated as writes=0; pending[0] SHALL always read 0.
REQ-018 Each register 1-31 SHALL hold a 2-bit in-flight write count, range 0-3.
REQ-019 stall SHALL assert when issue_valid and any of: (chk_a_en and pending[chk_a]), (chk_b_en and pending[chk_b]), (writes and count[target]=3), (md_busy and not md_done).
REQ-020 An issue SHALL be accepted on any clock edge with issue_valid=1 and stall=0; accepted writes SHALL increment count[target].
REQ-021 Accepted issue with opcode 00000 and aluop 00110 (mul) or 00111 (div) SHALL set md_busy next cycle.
REQ-022 md_done SHALL clear md_busy next cycle; md_done with md_busy=0 SHALL be ignored.
REQ-023 md_done and accepted mul/div in the same cycle SHALL leave md_busy=1.
REQ-024 wb_valid with wb_reg nonzero SHALL decrement count[wb_reg]; wb_reg=0 SHALL be ignored.
REQ-025 Increment and decrement of the same register in one cycle SHALL leave its count unchanged.
REQ-026 Decrement of a count already 0 SHALL leave it at 0 and set err.
REQ-027 stall SHALL not depend on same-cycle wb_valid (no writeback bypass through the scoreboard).
REQ-028 Latency: an accepted write SHALL appear in pending on the next cycle; a retire SHALL clear pending the next cycle when count reaches 0.

Reset
REQ-029 reset=0 at a rising edge SHALL clear all counts, md_busy, err; pending SHALL read 0.
REQ-030 reset SHALL override any same-cycle issue, wb_valid, or md_done, including mid-mul/div.
REQ-031 While reset=0, stall SHALL still evaluate combinationally from the cleared state.

Verification
REQ-032 Reset, then issue addi rd=5 -> pending=0x00000020 next cycle; check chk_a=5 en -> stall=1; wb_valid wb_reg=5 -> pending=0, stall=0.
REQ-033 Issue three lw rd=7 back-to-back, no retires -> count[7]=3; fourth lw rd=7 -> stall=1, count stays 3.
REQ-034 Same cycle: accept addi rd=9 and wb_valid wb_reg=9 with count[9]=1 -> count[9] remains 1, pending[9]=1.
REQ-035 Issue mul (00000/00110) rd=3 -> md_busy=1; any issue -> stall=1 until md_done pulse; md_done cycle -> stall=0, md_busy=0 next cycle.
REQ-036 wb_valid wb_reg=12 with count[12]=0 -> err=1 sticky, count[12]=0; wb_reg=0 -> no change, err unchanged.
REQ-037 jal then setx -> pending=0x C0000000 (bits 31, 30); reset=0 with md_busy=1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/write_scoreboard_if.sv
// Decode/writeback side-band bundle for the write scoreboard.
// master: the pipeline driving issue/writeback/multdiv events.
// slave : the scoreboard answering with stall and status.
interface write_scoreboard_if;
    logic        issue_valid;
    logic [4:0]  issue_opcode;
    logic [4:0]  issue_aluop;
    logic [4:0]  issue_rd;
    logic        chk_a_en;
    logic        chk_b_en;
    logic [4:0]  chk_a;
    logic [4:0]  chk_b;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic        md_done;
    logic        stall;
    logic        md_busy;
    logic [31:0] pending;
    logic        err;

    modport master (
        output issue_valid, issue_opcode, issue_aluop, issue_rd,
        output chk_a_en, chk_b_en, chk_a, chk_b,
        output wb_valid, wb_reg, md_done,
        input  stall, md_busy, pending, err
    );

    modport slave (
        input  issue_valid, issue_opcode, issue_aluop, issue_rd,
        input  chk_a_en, chk_b_en, chk_a, chk_b,
        input  wb_valid, wb_reg, md_done,
        output stall, md_busy, pending, err
    );
endinterface

// File: rtl/write_scoreboard.sv
// Register write scoreboard: tracks up to three in-flight writes per
// architectural register, stalls decode on RAW hazards, counter
// saturation and an outstanding multiply/divide, and flags retire
// underflow as a sticky error.
module write_scoreboard (
    input  logic              clock,
    input  logic              reset,
    write_scoreboard_if.slave sb
);

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    localparam logic [1:0] CNT_MAX = 2'd3;

    // State: per-register 2-bit in-flight counts, plus derived status flops.
    logic [31:0][1:0] count_q, count_d;
    logic [31:0]      pending_q, pending_d;
    logic             md_busy_q, md_busy_d;
    logic             err_q, err_d;

    // Decode results for the instruction currently presented.
    logic       writes;
    logic [4:0] target;
    logic       is_muldiv;
    logic       stall;
    logic       accept;
    logic       do_inc;
    logic       do_dec;

    // Decode which register, if any, the presented instruction will write.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case leaves a value unassigned (no latch).
        writes = 1'b0;
        target = sb.issue_rd;
        case (sb.issue_opcode)
            OP_ALU, OP_ADDI, OP_LW: writes = 1'b1;
            OP_JAL: begin
                writes = 1'b1;
                target = 5'd31;
            end
            OP_SETX: begin
                writes = 1'b1;
                target = 5'd30;
            end
            default: writes = 1'b0;
        endcase
        // r0 is hardwired; writes to it are never tracked.
        if (target == 5'd0) begin
            writes = 1'b0;
        end
        is_muldiv = (sb.issue_opcode == OP_ALU) &&
                    ((sb.issue_aluop == ALU_MUL) || (sb.issue_aluop == ALU_DIV));
    end

    // Hazard detection; deliberately ignores same-cycle writeback (no bypass).
    always_comb begin
        stall = sb.issue_valid &&
                ((sb.chk_a_en && pending_q[sb.chk_a]) ||
                 (sb.chk_b_en && pending_q[sb.chk_b]) ||
                 (writes && (count_q[target] == CNT_MAX)) ||
                 (md_busy_q && !sb.md_done));
        accept = sb.issue_valid && !stall;
        do_inc = accept && writes;
        do_dec = sb.wb_valid && (sb.wb_reg != 5'd0);
    end

    // Next-state for counts, pending mirror and the sticky underflow flag.
    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        for (int i = 1; i < 32; i++) begin
            if (do_inc && (target == 5'(i)) && !(do_dec && (sb.wb_reg == 5'(i)))) begin
                count_d[i] = count_q[i] + 2'd1;
            end else if (do_dec && (sb.wb_reg == 5'(i)) && !(do_inc && (target == 5'(i)))) begin
                if (count_q[i] == 2'd0) begin
                    err_d = 1'b1;
                end else begin
                    count_d[i] = count_q[i] - 2'd1;
                end
            end
        end
        count_d[0] = 2'd0;
        for (int i = 0; i < 32; i++) begin
            pending_d[i] = (count_d[i] != 2'd0);
        end
    end

    // Multiply/divide occupancy: a new accepted mul/div wins over md_done.
    always_comb begin
        md_busy_d = md_busy_q;
        if (accept && is_muldiv) begin
            md_busy_d = 1'b1;
        end else if (sb.md_done) begin
            md_busy_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge value regardless of statement order.
        if (!reset) begin
            // NOTE: the count array is ordinary flops, not a RAM, so it is
            // cleared by reset like any other state.
            count_q   <= '0;
            pending_q <= '0;
            md_busy_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            pending_q <= pending_d;
            md_busy_q <= md_busy_d;
            err_q     <= err_d;
        end
    end

    assign sb.stall   = stall;
    assign sb.md_busy = md_busy_q;
    assign sb.pending = pending_q;
    assign sb.err     = err_q;

endmodule

// File: tb/tb_write_scoreboard.sv
// Self-checking bench for write_scoreboard: directed scenarios followed by
// randomized traffic, all compared against a count-array reference model.
module tb_write_scoreboard;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    write_scoreboard_if sb ();

    write_scoreboard dut (
        .clock (clock),
        .reset (reset),
        .sb    (sb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: plain integer in-flight counts per register.
    int cnt [32];
    bit m_busy;
    bit m_err;

    // Register the instruction writes, 0 meaning "no tracked write".
    function automatic int dest_of(logic [4:0] op, logic [4:0] rd);
        int t;
        if (op == 5'b00000 || op == 5'b00101 || op == 5'b01000) t = int'(rd);
        else if (op == 5'b00011) t = 31;
        else if (op == 5'b10101) t = 30;
        else t = 0;
        return t;
    endfunction

    function automatic bit model_stall();
        int t;
        bit s;
        t = dest_of(sb.issue_opcode, sb.issue_rd);
        s = 1'b0;
        if (sb.chk_a_en && cnt[sb.chk_a] > 0) s = 1'b1;
        if (sb.chk_b_en && cnt[sb.chk_b] > 0) s = 1'b1;
        if (t != 0 && cnt[t] == 3) s = 1'b1;
        if (m_busy && !sb.md_done) s = 1'b1;
        return sb.issue_valid && s;
    endfunction

    function automatic logic [31:0] model_pending();
        logic [31:0] p;
        p = '0;
        for (int i = 1; i < 32; i++) p[i] = (cnt[i] > 0);
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check stall before the edge, advance the model at the edge,
    // check registered outputs half a cycle later.
    task automatic tick(input string tag);
        bit exp_stall;
        bit acc;
        int t;
        int nv;
        #1;
        exp_stall = model_stall();
        check({tag, ".stall"}, {31'd0, sb.stall}, {31'd0, exp_stall});
        acc = sb.issue_valid && !exp_stall;
        t   = dest_of(sb.issue_opcode, sb.issue_rd);
        @(posedge clock);
        if (!reset) begin
            for (int i = 0; i < 32; i++) cnt[i] = 0;
            m_busy = 1'b0;
            m_err  = 1'b0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                nv = cnt[i];
                if (acc && t == i) nv++;
                if (sb.wb_valid && int'(sb.wb_reg) == i) nv--;
                if (nv < 0) begin
                    m_err = 1'b1;
                    nv = 0;
                end
                cnt[i] = nv;
            end
            if (acc && sb.issue_opcode == 5'b00000 &&
                (sb.issue_aluop == 5'b00110 || sb.issue_aluop == 5'b00111))
                m_busy = 1'b1;
            else if (sb.md_done)
                m_busy = 1'b0;
        end
        @(negedge clock);
        check({tag, ".md_busy"}, {31'd0, sb.md_busy}, {31'd0, m_busy});
        check({tag, ".pending"}, sb.pending, model_pending());
        check({tag, ".err"}, {31'd0, sb.err}, {31'd0, m_err});
    endtask

    task automatic idle();
        reset           = 1'b1;
        sb.issue_valid  = 1'b0;
        sb.issue_opcode = 5'b00010;
        sb.issue_aluop  = 5'd0;
        sb.issue_rd     = 5'd0;
        sb.chk_a_en     = 1'b0;
        sb.chk_b_en     = 1'b0;
        sb.chk_a        = 5'd0;
        sb.chk_b        = 5'd0;
        sb.wb_valid     = 1'b0;
        sb.wb_reg       = 5'd0;
        sb.md_done      = 1'b0;
    endtask

    task automatic issue(input logic [4:0] op, input logic [4:0] alu, input logic [4:0] rd);
        sb.issue_valid  = 1'b1;
        sb.issue_opcode = op;
        sb.issue_aluop  = alu;
        sb.issue_rd     = rd;
    endtask

    task automatic retire(input logic [4:0] r);
        sb.wb_valid = 1'b1;
        sb.wb_reg   = r;
    endtask

    logic [4:0] op_tab [8];

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) cnt[i] = 0;
        m_busy = 1'b0;
        m_err  = 1'b0;
        op_tab[0] = 5'b00000; op_tab[1] = 5'b00101; op_tab[2] = 5'b01000;
        op_tab[3] = 5'b00011; op_tab[4] = 5'b10101; op_tab[5] = 5'b00010;
        op_tab[6] = 5'b11111; op_tab[7] = 5'b00000;

        idle();
        reset = 1'b0;
        @(negedge clock);
        tick("reset0");
        tick("reset1");
        check("reset.pending_zero", sb.pending, 32'h0);

        // addi rd=5, then RAW check on r5, then retire.
        idle(); issue(5'b00101, 5'd0, 5'd5); tick("addi5");
        check("addi5.pending_value", sb.pending, 32'h0000_0020);
        idle(); issue(5'b00010, 5'd0, 5'd0); sb.chk_a_en = 1'b1; sb.chk_a = 5'd5;
        #1 check("raw5.stall_high", {31'd0, sb.stall}, 32'd1);
        tick("raw5");
        idle(); retire(5'd5); tick("wb5");
        idle(); issue(5'b00010, 5'd0, 5'd0); sb.chk_a_en = 1'b1; sb.chk_a = 5'd5;
        tick("raw5_clear");

        // Saturate r7 at three in-flight writes.
        for (int k = 0; k < 3; k++) begin
            idle(); issue(5'b01000, 5'd0, 5'd7); tick("lw7");
        end
        idle(); issue(5'b01000, 5'd0, 5'd7);
        #1 check("lw7_full.stall_high", {31'd0, sb.stall}, 32'd1);
        tick("lw7_full");
        for (int k = 0; k < 3; k++) begin
            idle(); retire(5'd7); tick("wb7");
        end

        // Same-cycle increment and decrement on r9.
        idle(); issue(5'b00101, 5'd0, 5'd9); tick("addi9");
        idle(); issue(5'b00101, 5'd0, 5'd9); retire(5'd9); tick("addi9_wb9");
        check("addi9_wb9.bit9", {31'd0, sb.pending[9]}, 32'd1);
        idle(); retire(5'd9); tick("wb9");

        // mul blocks issue until md_done.
        idle(); issue(5'b00000, 5'b00110, 5'd3); tick("mul3");
        for (int k = 0; k < 3; k++) begin
            idle(); issue(5'b00101, 5'd0, 5'd4); tick("mul_wait");
        end
        idle(); issue(5'b00101, 5'd0, 5'd4); sb.md_done = 1'b1; tick("md_done");
        idle(); retire(5'd3); tick("wb3");
        idle(); retire(5'd4); tick("wb4");

        // Underflow is sticky; r0 retire is ignored.
        idle(); retire(5'd12); tick("wb12_underflow");
        idle(); retire(5'd0); tick("wb0");
        idle(); tick("err_hold");

        // jal + setx, then reset in the middle of a multiply.
        idle(); issue(5'b00011, 5'd0, 5'd1); tick("jal");
        idle(); issue(5'b10101, 5'd0, 5'd2); tick("setx");
        check("jal_setx.pending_value", sb.pending, 32'hC000_0000);
        idle(); issue(5'b00000, 5'b00111, 5'd6); tick("div6");
        idle(); reset = 1'b0; issue(5'b00101, 5'd0, 5'd8); retire(5'd30); sb.md_done = 1'b1;
        tick("reset_mid_div");
        check("reset_mid_div.all_zero", {sb.pending[30:0], sb.md_busy}, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            int live [$];
            idle();
            reset           = ($urandom_range(0, 59) != 0);
            sb.issue_valid  = $urandom_range(0, 1);
            sb.issue_opcode = op_tab[$urandom_range(0, 7)];
            sb.issue_aluop  = 5'($urandom_range(0, 7));
            sb.issue_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
            sb.chk_a_en     = $urandom_range(0, 1);
            sb.chk_b_en     = $urandom_range(0, 1);
            sb.chk_a        = 5'($urandom_range(0, 9));
            sb.chk_b        = 5'($urandom_range(0, 31));
            for (int i = 1; i < 32; i++) if (cnt[i] > 0) live.push_back(i);
            sb.wb_valid = ($urandom_range(0, 2) != 0);
            if (live.size() > 0 && $urandom_range(0, 9) != 0)
                sb.wb_reg = 5'(live[$urandom_range(0, live.size() - 1)]);
            else
                sb.wb_reg = 5'($urandom_range(0, 7));
            sb.md_done = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
